// File: rtl/smvm_lane_packer_if.sv
// Entry stream into the lane packer and packed-beat bus out to the multiplier.
// The packer is the slave; the entry source / multiplier side is the master.
interface smvm_lane_packer_if #(
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_value;
    logic [31:0]            in_row;
    logic [31:0]            in_col;
    logic                   in_last;
    logic [LANES-1:0][31:0] out_values;
    logic [LANES-1:0][31:0] out_col_id;
    logic [LANES-1:0][31:0] out_row_id;
    logic                   out_rdy;

    modport slave (
        input  in_valid, in_value, in_row, in_col, in_last,
        output in_ready, out_values, out_col_id, out_row_id, out_rdy
    );

    modport master (
        output in_valid, in_value, in_row, in_col, in_last,
        input  in_ready, out_values, out_col_id, out_row_id, out_rdy
    );
endinterface

// File: rtl/smvm_lane_packer.sv
// Packs a serial COO nonzero stream into LANES-wide beats for the SpMV multiplier,
// flushing a padded partial beat at end of matrix and draining before job_done.
module smvm_lane_packer #(
    parameter int LANES        = 4,
    parameter int NUM_ROWS     = 128,
    parameter int PAD_ROW      = 128,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                start,
    smvm_lane_packer_if.slave   bus,
    output logic                job_done,
    output logic                err_row,
    output logic [15:0]         beat_count,
    output logic [31:0]         nnz_count
);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DCW   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
    logic                   out_rdy_q, out_rdy_d;
    logic                   err_row_q, err_row_d;
    logic [15:0]            beat_count_q, beat_count_d;
    logic [31:0]            nnz_count_q, nnz_count_d;
    logic [LANES-1:0][31:0] slot_val_q, slot_val_d;
    logic [LANES-1:0][31:0] slot_row_q, slot_row_d;
    logic [LANES-1:0][31:0] slot_col_q, slot_col_d;
    logic [LANES-1:0][31:0] beat_val_q, beat_val_d;
    logic [LANES-1:0][31:0] beat_row_q, beat_row_d;
    logic [LANES-1:0][31:0] beat_col_q, beat_col_d;

    logic        accept;
    logic        row_ok;
    logic        last_slot;
    logic [31:0] ent_val, ent_row, ent_col;

    assign accept    = bus.in_valid && (state_q == S_FILL);
    assign row_ok    = bus.in_row < 32'(NUM_ROWS);
    assign last_slot = (ptr_q == PTR_W'(LANES - 1));
    // Out-of-range rows are consumed but must never reach a real accumulator row.
    assign ent_val   = row_ok ? bus.in_value : 32'd0;
    assign ent_row   = row_ok ? bus.in_row   : 32'(PAD_ROW);
    assign ent_col   = row_ok ? bus.in_col   : 32'd0;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            drain_cnt_q  <= '0;
            out_rdy_q    <= 1'b0;
            err_row_q    <= 1'b0;
            beat_count_q <= '0;
            nnz_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            drain_cnt_q  <= drain_cnt_d;
            out_rdy_q    <= out_rdy_d;
            err_row_q    <= err_row_d;
            beat_count_q <= beat_count_d;
            nnz_count_q  <= nnz_count_d;
        end
    end

    // Lane data is only observable through out_rdy gating, so it carries no reset.
    always_ff @(posedge clk) begin
        slot_val_q <= slot_val_d;
        slot_row_q <= slot_row_d;
        slot_col_q <= slot_col_d;
        beat_val_q <= beat_val_d;
        beat_row_q <= beat_row_d;
        beat_col_q <= beat_col_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (accept && bus.in_last) state_d = last_slot ? S_DRAIN : S_FLUSH;
            S_FLUSH: state_d = S_DRAIN;
            S_DRAIN: if (!out_rdy_q && drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        drain_cnt_d  = '0;
        out_rdy_d    = 1'b0;
        err_row_d    = err_row_q;
        beat_count_d = beat_count_q;
        nnz_count_d  = nnz_count_q;
        slot_val_d   = slot_val_q;
        slot_row_d   = slot_row_q;
        slot_col_d   = slot_col_q;
        beat_val_d   = beat_val_q;
        beat_row_d   = beat_row_q;
        beat_col_d   = beat_col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d        = '0;
                    err_row_d    = 1'b0;
                    beat_count_d = '0;
                    nnz_count_d  = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    slot_val_d[ptr_q] = ent_val;
                    slot_row_d[ptr_q] = ent_row;
                    slot_col_d[ptr_q] = ent_col;
                    nnz_count_d       = nnz_count_q + 32'd1;
                    if (!row_ok) err_row_d = 1'b1;
                    if (last_slot) begin
                        beat_val_d   = slot_val_d;
                        beat_row_d   = slot_row_d;
                        beat_col_d   = slot_col_d;
                        out_rdy_d    = 1'b1;
                        beat_count_d = beat_count_q + 16'd1;
                        ptr_d        = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                // ptr_q is the first unused slot; everything from there up is padding.
                for (int i = 0; i < LANES; i++) begin
                    if (PTR_W'(i) < ptr_q) begin
                        beat_val_d[i] = slot_val_q[i];
                        beat_row_d[i] = slot_row_q[i];
                        beat_col_d[i] = slot_col_q[i];
                    end else begin
                        beat_val_d[i] = 32'd0;
                        beat_row_d[i] = 32'(PAD_ROW);
                        beat_col_d[i] = 32'd0;
                    end
                end
                out_rdy_d    = 1'b1;
                beat_count_d = beat_count_q + 16'd1;
                ptr_d        = '0;
            end
            S_DRAIN: begin
                // The final beat's own cycle is not part of the drain window.
                drain_cnt_d = out_rdy_q ? drain_cnt_q : drain_cnt_q + DCW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == S_FILL);
        bus.out_rdy  = out_rdy_q;
        job_done     = (state_q == S_DONE);
        err_row      = err_row_q;
        beat_count   = beat_count_q;
        nnz_count    = nnz_count_q;
        for (int i = 0; i < LANES; i++) begin
            bus.out_values[i] = out_rdy_q ? beat_val_q[i] : 32'd0;
            bus.out_col_id[i] = out_rdy_q ? beat_col_q[i] : 32'd0;
            bus.out_row_id[i] = out_rdy_q ? beat_row_q[i] : 32'(PAD_ROW);
        end
    end
endmodule

// File: tb/tb_smvm_lane_packer.sv
// Scoreboard bench for smvm_lane_packer: directed jobs push expected beats and job
// summaries; a negedge monitor pops and compares whenever out_rdy or job_done fires.
module tb_smvm_lane_packer;
    logic        clk;
    logic        rst_l;
    logic        start;
    logic        job_done;
    logic        err_row;
    logic [15:0] beat_count;
    logic [31:0] nnz_count;

    smvm_lane_packer_if #(.LANES(4)) bus ();

    smvm_lane_packer #(
        .LANES(4), .NUM_ROWS(128), .PAD_ROW(128), .DRAIN_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .bus        (bus),
        .job_done   (job_done),
        .err_row    (err_row),
        .beat_count (beat_count),
        .nnz_count  (nnz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][31:0] v;
        logic [3:0][31:0] r;
        logic [3:0][31:0] c;
    } beat_t;

    typedef struct {
        logic [15:0] bc;
        logic [31:0] nnz;
        logic        err;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cycle  = 0;
    int    last_rdy_cycle = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [3:0][31:0] v, input logic [3:0][31:0] r,
                             input logic [3:0][31:0] c);
        beat_t b;
        b.v = v; b.r = r; b.c = c;
        exp_beats.push_back(b);
    endtask

    task automatic push_done(input logic [15:0] bc, input logic [31:0] nnz, input logic err);
        done_t d;
        d.bc = bc; d.nnz = nnz; d.err = err;
        exp_done.push_back(d);
    endtask

    // Monitor: all comparisons of emitted beats and job completions happen here.
    always @(negedge clk) begin
        cycle++;
        if (bus.out_rdy === 1'b1) begin
            if (exp_beats.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                check("beat_values", bus.out_values, b.v);
                check("beat_rows",   bus.out_row_id, b.r);
                check("beat_cols",   bus.out_col_id, b.c);
            end
            last_rdy_cycle = cycle;
        end
        if (job_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("unexpected_job_done", 1, 0);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_after_beat", cycle - last_rdy_cycle, 5);
                check("done_beat_count", beat_count, d.bc);
                check("done_nnz_count",  nnz_count, d.nnz);
                check("done_err_row",    err_row, d.err);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input logic [31:0] r, input logic [31:0] c,
                        input logic last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_row   = r;
        bus.in_col   = c;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while ((exp_done.size() != 0 || exp_beats.size() != 0) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) check(name, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_row   = '0;
        bus.in_col   = '0;
        bus.in_last  = 1'b0;

        // Reset and idle outputs
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check("rst_out_rdy",    bus.out_rdy, 0);
        check("rst_job_done",   job_done, 0);
        check("rst_in_ready",   bus.in_ready, 0);
        check("rst_row_ids",    bus.out_row_id, {4{32'd128}});
        check("rst_values",     bus.out_values, 0);
        check("rst_cols",       bus.out_col_id, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_nnz_count",  nnz_count, 0);
        check("rst_err_row",    err_row, 0);

        // Single full beat, last on the fourth entry
        push_beat({32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1},
                  {32'd4, 32'd3, 32'd2, 32'd1});
        push_done(16'd1, 32'd4, 1'b0);
        pulse_start();
        check("fill_in_ready", bus.in_ready, 1);
        for (int i = 1; i <= 4; i++) send(i, i, i, i == 4);
        check("full_beat_latency", bus.out_rdy, 1);
        wait_done("full_job_timeout");

        // Partial flush: six entries
        push_beat({32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1},
                  {32'd4, 32'd3, 32'd2, 32'd1});
        push_beat({32'd0, 32'd0, 32'd6, 32'd5}, {32'd128, 32'd128, 32'd6, 32'd5},
                  {32'd0, 32'd0, 32'd6, 32'd5});
        push_done(16'd2, 32'd6, 1'b0);
        pulse_start();
        for (int i = 1; i <= 6; i++) send(i, i, i, i == 6);
        check("flush_cycle_no_rdy", bus.out_rdy, 0);
        check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("flush_beat_latency", bus.out_rdy, 1);
        wait_done("flush_job_timeout");

        // Out-of-range row on lane 1
        push_beat({32'd4, 32'd3, 32'd0, 32'd1}, {32'd4, 32'd3, 32'd128, 32'd1},
                  {32'd4, 32'd3, 32'd0, 32'd1});
        push_done(16'd1, 32'd4, 1'b1);
        pulse_start();
        send(1, 1, 1, 0);
        send(2, 200, 2, 0);
        check("err_row_set", err_row, 1);
        send(3, 3, 3, 0);
        send(4, 4, 4, 1);
        wait_done("oor_job_timeout");
        check("err_row_sticky", err_row, 1);

        // Next start clears err_row; gapped valid and a stray start in FILL
        push_beat({32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1},
                  {32'd4, 32'd3, 32'd2, 32'd1});
        push_done(16'd1, 32'd4, 1'b0);
        pulse_start();
        check("err_row_cleared", err_row, 0);
        check("start_clears_nnz", nnz_count, 0);
        send(1, 1, 1, 0);
        send(2, 2, 2, 0);
        repeat (3) @(negedge clk);
        pulse_start();
        check("stray_start_nnz", nnz_count, 2);
        send(3, 3, 3, 0);
        send(4, 4, 4, 1);
        wait_done("gap_job_timeout");

        // Reset mid-FILL aborts silently
        pulse_start();
        send(9, 9, 9, 0);
        send(10, 10, 10, 0);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_nnz_count", nnz_count, 0);
        check("abort_out_rdy", bus.out_rdy, 0);

        push_beat({32'd14, 32'd13, 32'd12, 32'd11}, {32'd14, 32'd13, 32'd12, 32'd11},
                  {32'd24, 32'd23, 32'd22, 32'd21});
        push_done(16'd1, 32'd4, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) send(11 + i, 11 + i, 21 + i, i == 3);
        wait_done("post_abort_job_timeout");

        // Single-entry job: stale slots from earlier jobs must be padded out
        push_beat({32'd0, 32'd0, 32'd0, 32'd7}, {32'd128, 32'd128, 32'd128, 32'd7},
                  {32'd0, 32'd0, 32'd0, 32'd17});
        push_done(16'd1, 32'd1, 1'b0);
        pulse_start();
        send(7, 7, 17, 1);
        wait_done("single_job_timeout");

        repeat (3) @(negedge clk);
        check("beats_left", exp_beats.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
